// File: rtl/lcd_spi_engine_pkg.sv
// lcd_pkg: shared types and constants for the ST7789 SPI write engine and the
// init/pixel sequencers that feed it.
//   - lcd_state_e : engine FSM states
//   - lcd_word_t  : FIFO word {wide, dc, data}
//   - LCD_OP_*    : ST7789 opcodes for upstream sequencers
//   - LCD_*_DEF   : default timing for a 3.4 MHz system clock
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } lcd_state_e;

  typedef struct packed {
    logic        wide;  // 1: 16-bit frame, 0: 8-bit frame
    logic        dc;    // 0: command, 1: data
    logic [15:0] data;
  } lcd_word_t;

  localparam int LCD_WORD_W = $bits(lcd_word_t);

  localparam logic [7:0] LCD_OP_SWRESET = 8'h01;
  localparam logic [7:0] LCD_OP_SLPOUT  = 8'h11;
  localparam logic [7:0] LCD_OP_COLMOD  = 8'h3A;
  localparam logic [7:0] LCD_OP_MADCTL  = 8'h36;
  localparam logic [7:0] LCD_OP_CASET   = 8'h2A;
  localparam logic [7:0] LCD_OP_RASET   = 8'h2B;
  localparam logic [7:0] LCD_OP_RAMWR   = 8'h2C;
  localparam logic [7:0] LCD_OP_DISPON  = 8'h29;

  localparam int LCD_CLK_DIV_DEF    = 2;
  localparam int LCD_FIFO_DEPTH_DEF = 4;
  localparam int LCD_RST_LOW_DEF    = 34;      // 10 us
  localparam int LCD_RST_WAIT_DEF   = 408000;  // 120 ms
  localparam int LCD_CS_IDLE_DEF    = 2;

  // Left-justify the payload so the first bit on the wire is always bit 15.
  function automatic logic [15:0] lcd_align(input lcd_word_t w);
    return w.wide ? w.data : {w.data[7:0], 8'h00};
  endfunction

endpackage

// File: rtl/lcd_spi_engine_if.sv
// lcd_spi_engine_if: valid/ready word stream into the SPI engine.
//   in_valid/in_ready : handshake, transfer when both high at a clk edge
//   in_data           : payload, MSB first ([7:0] only for 8-bit frames)
//   in_dc             : driven onto lcd_rs for the frame
//   in_wide           : 1 = 16-bit frame, 0 = 8-bit frame
// master = upstream sequencer, slave = engine.
interface lcd_spi_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_dc;
  logic        in_wide;

  modport master (output in_valid, output in_data, output in_dc, output in_wide,
                  input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_dc, input  in_wide,
                  output in_ready);
endinterface

// File: rtl/lcd_spi_engine_fifo.sv
// lcd_word_fifo: synchronous FIFO holding {wide, dc, data} words.
//   clk, rst      : clock, async active-low reset (flushes contents)
//   push_i/wdata_i: write, ignored when full
//   pop_i/rdata_o : read, rdata_o is the head word (valid when !empty_o)
//   full_o/empty_o: registered-count status flags
module lcd_word_fifo #(
  parameter int DEPTH = 4,   // power of 2, >= 2
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/lcd_spi_engine.sv
// lcd_spi_engine: 4-wire SPI write engine for ST7789 panels.
// Runs the panel hardware-reset sequence, then serialises buffered
// command/data words as 8- or 16-bit mode-0 frames.
//   clk, rst   : system clock, async active-low reset
//   in_if      : word stream (slave side)
//   busy       : FIFO non-empty or frame/gap in progress
//   init_done  : panel reset sequence complete (sticky)
//   lcd_rst    : panel reset, active-low
//   lcd_rs     : D/C select, held for the whole frame
//   lcd_sd     : serial data, changes on SCK falling edge
//   lcd_sck    : serial clock, idle low
//   lcd_cs     : chip select, active-low, held across back-to-back frames
module lcd_spi_engine
  import lcd_pkg::*;
#(
  parameter int CLK_DIV         = LCD_CLK_DIV_DEF,
  parameter int FIFO_DEPTH      = LCD_FIFO_DEPTH_DEF,
  parameter int RST_LOW_CYCLES  = LCD_RST_LOW_DEF,
  parameter int RST_WAIT_CYCLES = LCD_RST_WAIT_DEF,
  parameter int CS_IDLE_CYCLES  = LCD_CS_IDLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  lcd_spi_engine_if.slave   in_if,
  output logic              busy,
  output logic              init_done,
  output logic              lcd_rst,
  output logic              lcd_rs,
  output logic              lcd_sd,
  output logic              lcd_sck,
  output logic              lcd_cs
);
  // One timer serves the reset phases and the CS hold; sized for the longest.
  localparam int TMR_MAX = (RST_WAIT_CYCLES > RST_LOW_CYCLES)
                         ? ((RST_WAIT_CYCLES > CS_IDLE_CYCLES) ? RST_WAIT_CYCLES : CS_IDLE_CYCLES)
                         : ((RST_LOW_CYCLES  > CS_IDLE_CYCLES) ? RST_LOW_CYCLES  : CS_IDLE_CYCLES);
  localparam int TW    = $clog2(TMR_MAX + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [TW-1:0]    LOW_LAST  = TW'(RST_LOW_CYCLES - 1);
  localparam logic [TW-1:0]    WAIT_LAST = TW'(RST_WAIT_CYCLES - 1);
  localparam logic [TW-1:0]    GAP_LAST  = TW'(CS_IDLE_CYCLES - 1);
  localparam logic [TW-1:0]    TMR_SAT   = TW'(TMR_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  lcd_state_e       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bits_q, bits_d;
  logic [14:0]      sh_q, sh_d;     // bits still to send after the one on lcd_sd
  logic             sd_q, sd_d;
  logic             rs_q, rs_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             lrst_q, lrst_d;
  logic             init_q, init_d;

  lcd_word_t        head;
  logic [15:0]      aligned;
  logic             fifo_full, fifo_empty, push, pop;
  logic             div_hit, frame_end;

  // FIFO
  assign push = in_if.in_valid && in_if.in_ready;

  lcd_word_fifo #(.DEPTH(FIFO_DEPTH), .W(LCD_WORD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({in_if.in_wide, in_if.in_dc, in_if.in_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign aligned   = lcd_align(head);
  assign div_hit   = (div_q == DIV_LAST);
  // Last bit ends on the falling edge of its SCK period.
  assign frame_end = sck_q && div_hit && (bits_q == 5'd1);

  // Decoded from flops only: no combinational path from inputs.
  assign in_if.in_ready = init_q && !fifo_full;
  assign busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT) ||
                (state_q == ST_GAP)  || !fifo_empty;

  assign init_done = init_q;
  assign lcd_rst   = lrst_q;
  assign lcd_rs    = rs_q;
  assign lcd_sd    = sd_q;
  assign lcd_sck   = sck_q;
  assign lcd_cs    = cs_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RST_LOW;
      tmr_q   <= '0;
      div_q   <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      sd_q    <= 1'b0;
      rs_q    <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      lrst_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      sd_q    <= sd_d;
      rs_q    <= rs_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      lrst_q  <= lrst_d;
      init_q  <= init_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST_LOW:  if (tmr_q == LOW_LAST)  state_d = ST_RST_WAIT;
      ST_RST_WAIT: if (tmr_q == WAIT_LAST) state_d = ST_IDLE;
      ST_IDLE:     if (!fifo_empty)        state_d = ST_LOAD;
      ST_LOAD:                             state_d = ST_SHIFT;
      ST_SHIFT:    if (frame_end)          state_d = fifo_empty ? ST_GAP : ST_LOAD;
      ST_GAP: begin
        // A new word wins over the CS-release timeout.
        if (!fifo_empty)            state_d = ST_LOAD;
        else if (tmr_q == GAP_LAST) state_d = ST_IDLE;
      end
      default:                             state_d = ST_RST_LOW;
    endcase
  end

  // Outputs / datapath
  always_comb begin
    tmr_d  = (state_d != state_q) ? '0 : ((tmr_q == TMR_SAT) ? tmr_q : tmr_q + TW'(1));
    div_d  = div_q;
    bits_d = bits_q;
    sh_d   = sh_q;
    sd_d   = sd_q;
    rs_d   = rs_q;
    cs_d   = cs_q;
    sck_d  = sck_q;
    lrst_d = lrst_q;
    init_d = init_q;
    pop    = 1'b0;
    unique case (state_q)
      ST_RST_LOW:  if (tmr_q == LOW_LAST)  lrst_d = 1'b1;
      ST_RST_WAIT: if (tmr_q == WAIT_LAST) init_d = 1'b1;
      ST_LOAD: begin
        pop    = 1'b1;
        sd_d   = aligned[15];
        sh_d   = aligned[14:0];
        bits_d = head.wide ? 5'd16 : 5'd8;
        rs_d   = head.dc;
        cs_d   = 1'b0;
        sck_d  = 1'b0;
        div_d  = '0;
      end
      ST_SHIFT: begin
        if (div_hit) begin
          div_d = '0;
          sck_d = !sck_q;
          if (sck_q) begin
            // Falling edge: present the next bit.
            sd_d   = sh_q[14];
            sh_d   = {sh_q[13:0], 1'b0};
            bits_d = bits_q - 5'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: if (fifo_empty && (tmr_q == GAP_LAST)) cs_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_spi_engine.sv
// Randomised bench for lcd_spi_engine. A pin-level monitor decodes SPI frames
// (bits sampled on SCK rising edges) and compares them, in order, against a
// queue of words the driver saw accepted; directed phases check reset timing,
// CS latency/hold, burst back-pressure, gap re-entry and mid-frame reset.
module tb_lcd_spi_engine;
  import lcd_pkg::*;

  localparam int CLK_DIV = 2, FIFO_DEPTH = 4, RST_LOW = 4, RST_WAIT = 10, CS_IDLE = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic busy, init_done, lcd_rst, lcd_rs, lcd_sd, lcd_sck, lcd_cs;

  lcd_spi_engine_if bus();

  lcd_spi_engine #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .RST_LOW_CYCLES(RST_LOW),
    .RST_WAIT_CYCLES(RST_WAIT), .CS_IDLE_CYCLES(CS_IDLE)
  ) dut (
    .clk(clk), .rst(rst), .in_if(bus), .busy(busy), .init_done(init_done),
    .lcd_rst(lcd_rst), .lcd_rs(lcd_rs), .lcd_sd(lcd_sd), .lcd_sck(lcd_sck), .lcd_cs(lcd_cs)
  );

  always #5 clk = ~clk;

  lcd_word_t   exp_q[$];
  int          vecs = 0, errs = 0, cyc = 0;
  int          mon_nbits = 0, mon_frames = 0, cs_rises = 0;
  int          cs_fall_c = 0, last_fall_c = 0, first_rise_c = 0, hs_cyc = 0;
  logic [15:0] mon_acc = '0;
  logic        prev_sck = 1'b0, prev_cs = 1'b1;
  bit          stalled = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pin monitor, sampled away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mon_nbits = 0; mon_acc = '0; prev_sck = 1'b0; prev_cs = 1'b1;
    end else begin
      if (lcd_sck && !prev_sck) begin
        if (exp_q.size() == 0) chk("unexpected_sck", 1, 0);
        else begin
          if (mon_nbits == 0) first_rise_c = cyc;
          chk("cs_low_at_sck", lcd_cs, 0);
          chk("rs_in_frame", lcd_rs, exp_q[0].dc);
          mon_acc = {mon_acc[14:0], lcd_sd};
          mon_nbits++;
          if (mon_nbits == (exp_q[0].wide ? 16 : 8)) begin
            chk("frame_data", mon_acc, exp_q[0].data);
            chk("bit_period", cyc - first_rise_c, (mon_nbits - 1) * 2 * CLK_DIV);
            void'(exp_q.pop_front());
            mon_nbits = 0; mon_acc = '0; mon_frames++;
          end
        end
      end
      if (!lcd_sck && prev_sck) last_fall_c = cyc;
      if (!lcd_cs && prev_cs)   cs_fall_c = cyc;
      if (lcd_cs && !prev_cs) begin
        cs_rises++;
        chk("cs_hold", cyc - last_fall_c, CS_IDLE);
      end
      prev_sck = lcd_sck;
      prev_cs  = lcd_cs;
    end
  end

  // Called at a negedge; leaves in_valid high and returns one negedge after the handshake.
  task automatic push_word(input logic [15:0] d, input logic dc, input logic w);
    int n = 0;
    lcd_word_t e;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_dc = dc; bus.in_wide = w;
    while (!bus.in_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n > 0) stalled = 1;
    if (n >= 4000) chk("push_timeout", 0, 1);
    else begin
      hs_cyc = cyc + 1;
      e.wide = w; e.dc = dc; e.data = w ? d : {8'h00, d[7:0]};
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !lcd_cs) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", n < 5000, 1);
    chk("all_words_sent", exp_q.size(), 0);
  endtask

  // Asserts reset shortly after a negedge, checks immediate output values, then
  // checks the panel reset sequence while a word is offered throughout.
  task automatic do_reset(input logic [15:0] d);
    bit drop = 0;
    lcd_word_t e;
    #2 rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    #1 chk("reset_outputs",
           {lcd_rst, lcd_cs, lcd_sck, lcd_sd, lcd_rs, bus.in_ready, init_done, busy}, 8'b0100_0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_dc = 1'b1; bus.in_wide = 1'b1;
    for (int k = 1; k <= RST_LOW + RST_WAIT + 2; k++) begin
      @(negedge clk);
      chk("lcd_rst_seq",   lcd_rst,      k >= RST_LOW);
      chk("init_done_seq", init_done,    k >= RST_LOW + RST_WAIT);
      chk("in_ready_seq",  bus.in_ready, k >= RST_LOW + RST_WAIT);
      if (drop) bus.in_valid = 1'b0;
      else if (bus.in_ready) begin
        e.wide = 1'b1; e.dc = 1'b1; e.data = d;
        exp_q.push_back(e);
        drop = 1;
      end
    end
  endtask

  initial begin
    int r0, f0, n, exp_len;
    logic w;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dc = 1'b0; bus.in_wide = 1'b0;
    repeat (2) @(negedge clk);

    // Reset sequence, word held upstream until init_done
    do_reset(16'h1234);
    wait_idle();

    // 8-bit command: latency, bit order, rs, cs hold (monitor)
    push_word({8'h00, LCD_OP_CASET}, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    wait_idle();
    chk("cs_latency", cs_fall_c - hs_cyc, 2);

    // 16-bit pixel data, full frame length
    push_word(16'hF800, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    wait_idle();
    chk("frame16_len", last_fall_c - cs_fall_c, 16 * 2 * CLK_DIV);

    // Burst of 6 with valid held: back-pressure, single CS window, contiguous frames
    stalled = 0; r0 = cs_rises; exp_len = 0;
    for (int i = 0; i < 6; i++) begin
      w = 1'($urandom_range(0, 1));
      push_word(16'($urandom), 1'($urandom_range(0, 1)), w);
      exp_len += (w ? 16 : 8) * 2 * CLK_DIV;
    end
    bus.in_valid = 1'b0;
    wait_idle();
    chk("burst_stall_seen", stalled, 1);
    chk("burst_cs_rises", cs_rises - r0, 1);
    chk("burst_len", last_fall_c - cs_fall_c, exp_len + 5);

    // Word offered one cycle into the CS hold gap
    r0 = cs_rises; f0 = mon_frames; n = 0;
    push_word(16'($urandom), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    while (mon_frames == f0 && n < 500) begin @(negedge clk); n++; end
    while (lcd_sck && n < 500) begin @(negedge clk); n++; end
    chk("gap_setup", n < 500, 1);
    push_word(16'($urandom), 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    wait_idle();
    chk("gap_no_cs_rise", cs_rises - r0, 1);

    // Reset during bit 3 of a 16-bit frame: word abandoned, sequence reruns
    push_word(16'($urandom), 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    n = 0;
    while (mon_nbits != 3 && n < 500) begin @(negedge clk); n++; end
    chk("mid_frame_reached", n < 500, 1);
    do_reset(16'hA5C3);
    wait_idle();

    // Random traffic with random idle gaps
    for (int i = 0; i < 40; i++) begin
      push_word(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 60)) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
